tcp_rx_demux: RTL and testbench

- Receive-side counterpart of the TCP TX arbitration mux, sitting between the IP RX path and the per-connection tcp_stream instances.
- Accepts IP packets with protocol 6 and buffers the first 4 TCP header bytes (source port, destination port).
- Matches the packet against per-stream connection config and steers header plus full payload to exactly one of NUM_TCP outputs.
- Unmatched, non-TCP or runt packets are consumed and dropped.

---
 rtl/tcp_rx_demux_pkg.sv | 24 ++
 rtl/tcp_rx_port_match.sv | 50 +++++
 rtl/tcp_rx_demux.sv | 243 ++++++++++++++++++++++++
 tb/tb_tcp_rx_demux.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_rx_demux_pkg.sv
// Shared types and constants for the TCP receive demultiplexer.
// The optional statistics counters are enabled by defining TCP_RX_DEMUX_STATS_EN.
package tcp_rx_demux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PORTS,
    MATCH,
    SEND_HDR,
    REPLAY,
    FWD,
    DROP,
    DROP_DONE
  } state_t;

  localparam logic [7:0] TCP_PROTO      = 8'd6;
  localparam int         PORT_HDR_BYTES = 4;

  // Width of a stream index; a single-stream build still needs one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tcp_rx_port_match.sv
// Combinational connection lookup: finds the lowest-indexed enabled stream whose
// local port, remote port (0 = any) and remote IP (0 = any) match the packet.
module tcp_rx_port_match
  import tcp_rx_demux_pkg::*;
#(
  parameter int NUM_TCP = 8
) (
  input  logic [NUM_TCP-1:0]              cfg_en,
  input  logic [NUM_TCP*16-1:0]           cfg_local_port,
  input  logic [NUM_TCP*16-1:0]           cfg_remote_port,
  input  logic [NUM_TCP*32-1:0]           cfg_remote_ip,
  input  logic [15:0]                     i_src_port,
  input  logic [15:0]                     i_dst_port,
  input  logic [31:0]                     i_source_ip,
  output logic                            o_hit,
  output logic [sel_width(NUM_TCP)-1:0]   o_sel
);

  localparam int SEL_W = sel_width(NUM_TCP);

  logic [NUM_TCP-1:0] w_hit_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TCP; gi++) begin : g_stream
      logic [15:0] w_lport;
      logic [15:0] w_rport;
      logic [31:0] w_rip;
      assign w_lport = cfg_local_port[gi*16 +: 16];
      assign w_rport = cfg_remote_port[gi*16 +: 16];
      assign w_rip   = cfg_remote_ip[gi*32 +: 32];
      assign w_hit_vec[gi] = cfg_en[gi]
                          && (w_lport == i_dst_port)
                          && ((w_rport == 16'd0) || (w_rport == i_src_port))
                          && ((w_rip == 32'd0) || (w_rip == i_source_ip));
    end
  endgenerate

  // Scan downwards so the lowest hitting index is the last one written.
  always_comb begin
    o_hit = |w_hit_vec;
    o_sel = '0;
    for (int i = NUM_TCP - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        o_sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/tcp_rx_demux.sv
// Steers received TCP packets to one of NUM_TCP stream outputs by port/IP lookup.
// Define TCP_RX_DEMUX_STATS_EN to add the drop_count and rx_count statistics ports.
module tcp_rx_demux
  import tcp_rx_demux_pkg::*;
#(
  parameter int NUM_TCP    = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    s_ip_hdr_valid,
  output logic                    s_ip_hdr_ready,
  input  logic [31:0]             s_ip_source_ip,
  input  logic [31:0]             s_ip_dest_ip,
  input  logic [7:0]              s_ip_protocol,
  input  logic [DATA_WIDTH-1:0]   s_ip_payload_tdata,
  input  logic                    s_ip_payload_tvalid,
  output logic                    s_ip_payload_tready,
  input  logic                    s_ip_payload_tlast,
  input  logic                    s_ip_payload_tuser,
  input  logic [NUM_TCP-1:0]      cfg_en,
  input  logic [NUM_TCP*16-1:0]   cfg_local_port,
  input  logic [NUM_TCP*16-1:0]   cfg_remote_port,
  input  logic [NUM_TCP*32-1:0]   cfg_remote_ip,
  output logic [NUM_TCP-1:0]      m_ip_hdr_valid,
  input  logic [NUM_TCP-1:0]      m_ip_hdr_ready,
  output logic [31:0]             m_ip_source_ip,
  output logic [31:0]             m_ip_dest_ip,
  output logic [DATA_WIDTH-1:0]   m_ip_payload_tdata,
  output logic [NUM_TCP-1:0]      m_ip_payload_tvalid,
  input  logic [NUM_TCP-1:0]      m_ip_payload_tready,
  output logic                    m_ip_payload_tlast,
  output logic                    m_ip_payload_tuser
`ifdef TCP_RX_DEMUX_STATS_EN
  ,
  output logic [15:0]             drop_count,
  output logic [NUM_TCP*16-1:0]   rx_count
`endif
);

  localparam int SEL_W = sel_width(NUM_TCP);

  state_t                r_state;
  state_t                w_state_next;
  logic [31:0]           r_src_ip;
  logic [31:0]           r_dst_ip;
  logic [7:0]            r_proto;
  logic [DATA_WIDTH-1:0] r_buf [PORT_HDR_BYTES];
  logic [1:0]            r_idx;
  logic                  r_ended;
  logic                  r_err;
  logic [SEL_W-1:0]      r_sel;

  logic                  w_hit;
  logic [SEL_W-1:0]      w_sel;
  logic                  w_hdr_valid;
  logic                  w_out_valid;
  logic                  w_out_ready;
  logic                  w_in_hs;
  logic [NUM_TCP-1:0]    w_onehot;

  tcp_rx_port_match #(.NUM_TCP(NUM_TCP)) u_match (
    .cfg_en          (cfg_en),
    .cfg_local_port  (cfg_local_port),
    .cfg_remote_port (cfg_remote_port),
    .cfg_remote_ip   (cfg_remote_ip),
    .i_src_port      ({r_buf[0], r_buf[1]}),
    .i_dst_port      ({r_buf[2], r_buf[3]}),
    .i_source_ip     (r_src_ip),
    .o_hit           (w_hit),
    .o_sel           (w_sel)
  );

  assign w_onehot            = NUM_TCP'(1) << r_sel;
  assign w_out_ready         = m_ip_payload_tready[r_sel];
  assign w_in_hs             = s_ip_payload_tvalid && s_ip_payload_tready;
  assign m_ip_hdr_valid      = w_hdr_valid ? w_onehot : '0;
  assign m_ip_payload_tvalid = w_out_valid ? w_onehot : '0;
  assign m_ip_source_ip      = r_src_ip;
  assign m_ip_dest_ip        = r_dst_ip;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next        = r_state;
    s_ip_hdr_ready      = 1'b0;
    s_ip_payload_tready = 1'b0;
    w_hdr_valid         = 1'b0;
    w_out_valid         = 1'b0;
    m_ip_payload_tdata  = '0;
    m_ip_payload_tlast  = 1'b0;
    m_ip_payload_tuser  = 1'b0;
    case (r_state)
      IDLE: begin
        s_ip_hdr_ready = !i_rst;
        if (s_ip_hdr_valid && !i_rst) begin
          w_state_next = (s_ip_protocol == TCP_PROTO) ? PORTS : DROP;
        end
      end
      PORTS: begin
        s_ip_payload_tready = 1'b1;
        if (s_ip_payload_tvalid) begin
          if (s_ip_payload_tlast && r_idx != 2'd3) begin
            w_state_next = DROP_DONE;
          end else if (r_idx == 2'd3) begin
            w_state_next = MATCH;
          end
        end
      end
      MATCH: begin
        if (w_hit && r_proto == TCP_PROTO) begin
          w_state_next = SEND_HDR;
        end else begin
          w_state_next = r_ended ? DROP_DONE : DROP;
        end
      end
      SEND_HDR: begin
        w_hdr_valid = 1'b1;
        if (m_ip_hdr_ready[r_sel]) begin
          w_state_next = REPLAY;
        end
      end
      REPLAY: begin
        w_out_valid        = 1'b1;
        m_ip_payload_tdata = r_buf[r_idx];
        m_ip_payload_tlast = r_ended && (r_idx == 2'd3);
        m_ip_payload_tuser = r_ended && (r_idx == 2'd3) && r_err;
        if (w_out_ready && r_idx == 2'd3) begin
          w_state_next = r_ended ? IDLE : FWD;
        end
      end
      FWD: begin
        s_ip_payload_tready = w_out_ready;
        w_out_valid         = s_ip_payload_tvalid;
        m_ip_payload_tdata  = s_ip_payload_tdata;
        m_ip_payload_tlast  = s_ip_payload_tlast;
        m_ip_payload_tuser  = s_ip_payload_tuser;
        if (s_ip_payload_tvalid && w_out_ready && s_ip_payload_tlast) begin
          w_state_next = IDLE;
        end
      end
      DROP: begin
        s_ip_payload_tready = 1'b1;
        if (s_ip_payload_tvalid && s_ip_payload_tlast) begin
          w_state_next = DROP_DONE;
        end
      end
      DROP_DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Packet context: latched addresses, buffered port bytes and replay cursor.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_src_ip <= '0;
      r_dst_ip <= '0;
      r_proto  <= '0;
      r_idx    <= '0;
      r_ended  <= 1'b0;
      r_err    <= 1'b0;
      r_sel    <= '0;
      for (int i = 0; i < PORT_HDR_BYTES; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (s_ip_hdr_valid) begin
            r_src_ip <= s_ip_source_ip;
            r_dst_ip <= s_ip_dest_ip;
            r_proto  <= s_ip_protocol;
            r_idx    <= '0;
            r_ended  <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        PORTS: begin
          if (w_in_hs) begin
            r_buf[r_idx] <= s_ip_payload_tdata;
            r_idx        <= r_idx + 2'd1;
            r_ended      <= s_ip_payload_tlast;
            r_err        <= r_err | s_ip_payload_tuser;
          end
        end
        MATCH: begin
          r_sel <= w_sel;
          r_idx <= '0;
        end
        REPLAY: begin
          if (w_out_ready) begin
            r_idx <= r_idx + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef TCP_RX_DEMUX_STATS_EN
  logic        w_out_hs;
  logic [15:0] r_drop_count;

  assign w_out_hs   = w_out_valid && w_out_ready;
  assign drop_count = r_drop_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_drop_count <= '0;
    end else if (r_state == DROP_DONE && r_drop_count != 16'hFFFF) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TCP; gi++) begin : g_rx_count
      logic [15:0] r_rx_count;
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_rx_count <= '0;
        end else if (w_out_hs && m_ip_payload_tlast && r_sel == SEL_W'(gi)
                     && r_rx_count != 16'hFFFF) begin
          r_rx_count <= r_rx_count + 16'd1;
        end
      end
      assign rx_count[gi*16 +: 16] = r_rx_count;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_tcp_rx_demux.sv
// Randomized scoreboard bench for tcp_rx_demux: a packet-level model predicts the
// delivered stream and byte sequence, and a monitor compares every output handshake.
module tb_tcp_rx_demux;

  localparam int N = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            s_ip_hdr_valid;
  logic            s_ip_hdr_ready;
  logic [31:0]     s_ip_source_ip;
  logic [31:0]     s_ip_dest_ip;
  logic [7:0]      s_ip_protocol;
  logic [7:0]      s_ip_payload_tdata;
  logic            s_ip_payload_tvalid;
  logic            s_ip_payload_tready;
  logic            s_ip_payload_tlast;
  logic            s_ip_payload_tuser;
  logic [N-1:0]    cfg_en;
  logic [N*16-1:0] cfg_local_port;
  logic [N*16-1:0] cfg_remote_port;
  logic [N*32-1:0] cfg_remote_ip;
  logic [N-1:0]    m_ip_hdr_valid;
  logic [N-1:0]    m_ip_hdr_ready;
  logic [31:0]     m_ip_source_ip;
  logic [31:0]     m_ip_dest_ip;
  logic [7:0]      m_ip_payload_tdata;
  logic [N-1:0]    m_ip_payload_tvalid;
  logic [N-1:0]    m_ip_payload_tready;
  logic            m_ip_payload_tlast;
  logic            m_ip_payload_tuser;
`ifdef TCP_RX_DEMUX_STATS_EN
  logic [15:0]     drop_count;
  logic [N*16-1:0] rx_count;
`endif

  logic [15:0] t_lport [N];
  logic [15:0] t_rport [N];
  logic [31:0] t_rip   [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cfg
      assign cfg_local_port[gi*16 +: 16]  = t_lport[gi];
      assign cfg_remote_port[gi*16 +: 16] = t_rport[gi];
      assign cfg_remote_ip[gi*32 +: 32]   = t_rip[gi];
    end
  endgenerate

  always #5 clk = ~clk;

  tcp_rx_demux #(.NUM_TCP(N), .DATA_WIDTH(8)) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .s_ip_hdr_valid      (s_ip_hdr_valid),
    .s_ip_hdr_ready      (s_ip_hdr_ready),
    .s_ip_source_ip      (s_ip_source_ip),
    .s_ip_dest_ip        (s_ip_dest_ip),
    .s_ip_protocol       (s_ip_protocol),
    .s_ip_payload_tdata  (s_ip_payload_tdata),
    .s_ip_payload_tvalid (s_ip_payload_tvalid),
    .s_ip_payload_tready (s_ip_payload_tready),
    .s_ip_payload_tlast  (s_ip_payload_tlast),
    .s_ip_payload_tuser  (s_ip_payload_tuser),
    .cfg_en              (cfg_en),
    .cfg_local_port      (cfg_local_port),
    .cfg_remote_port     (cfg_remote_port),
    .cfg_remote_ip       (cfg_remote_ip),
    .m_ip_hdr_valid      (m_ip_hdr_valid),
    .m_ip_hdr_ready      (m_ip_hdr_ready),
    .m_ip_source_ip      (m_ip_source_ip),
    .m_ip_dest_ip        (m_ip_dest_ip),
    .m_ip_payload_tdata  (m_ip_payload_tdata),
    .m_ip_payload_tvalid (m_ip_payload_tvalid),
    .m_ip_payload_tready (m_ip_payload_tready),
    .m_ip_payload_tlast  (m_ip_payload_tlast),
    .m_ip_payload_tuser  (m_ip_payload_tuser)
`ifdef TCP_RX_DEMUX_STATS_EN
    ,
    .drop_count          (drop_count),
    .rx_count            (rx_count)
`endif
  );

  typedef struct {
    int         stream;
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  typedef struct {
    int          stream;
    logic [31:0] sip;
    logic [31:0] dip;
  } hdr_t;

  beat_t exp_q[$];
  hdr_t  hexp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_drops = 0;
  int    exp_rx [N];
  int    bp_pct = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Connection lookup straight from the matching rules: first enabled stream wins.
  function automatic int model_match(input logic [15:0] sp, input logic [15:0] dp, input logic [31:0] sip);
    for (int i = 0; i < N; i++) begin
      if (cfg_en[i] && t_lport[i] == dp && (t_rport[i] == 0 || t_rport[i] == sp)
          && (t_rip[i] == 0 || t_rip[i] == sip)) return i;
    end
    return -1;
  endfunction

  // Sink: random per-stream backpressure.
  initial begin
    m_ip_payload_tready = '0;
    m_ip_hdr_ready      = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        m_ip_payload_tready[i] = ($urandom_range(0, 99) >= bp_pct);
        m_ip_hdr_ready[i]      = ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Monitor: compares each output handshake against the scoreboard queues.
  initial begin
    int    idx;
    beat_t b;
    hdr_t  h;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (m_ip_payload_tvalid != '0) begin
          check("tvalid_onehot", 64'($countones(m_ip_payload_tvalid)), 64'd1);
          if (s_ip_payload_tready)
            check("fwd_ready_mirror", 64'(|(m_ip_payload_tvalid & m_ip_payload_tready)), 64'd1);
        end
        if (|(m_ip_hdr_valid & m_ip_hdr_ready)) begin
          idx = oh_idx(m_ip_hdr_valid);
          if (hexp_q.size() == 0) begin
            check("unexpected_hdr_stream", 64'(idx), 64'hFFFF);
          end else begin
            h = hexp_q.pop_front();
            $display("hdr  stream=%0d sip=%08h dip=%08h", idx, m_ip_source_ip, m_ip_dest_ip);
            check("hdr_stream", 64'(idx), 64'(h.stream));
            check("hdr_source_ip", 64'(m_ip_source_ip), 64'(h.sip));
            check("hdr_dest_ip", 64'(m_ip_dest_ip), 64'(h.dip));
          end
        end
        if (|(m_ip_payload_tvalid & m_ip_payload_tready)) begin
          idx = oh_idx(m_ip_payload_tvalid);
          if (exp_q.size() == 0) begin
            check("unexpected_beat_stream", 64'(idx), 64'hFFFF);
          end else begin
            b = exp_q.pop_front();
            check("beat_stream", 64'(idx), 64'(b.stream));
            check("beat_data", 64'(m_ip_payload_tdata), 64'(b.data));
            check("beat_last", 64'(m_ip_payload_tlast), 64'(b.last));
            check("beat_user", 64'(m_ip_payload_tuser), 64'(b.user));
          end
        end
      end
    end
  end

  task automatic wait_hs(input bit is_hdr, input string name);
    bit hs;
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      hs = is_hdr ? s_ip_hdr_ready : s_ip_payload_tready;
      @(posedge clk);
      #1;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic send_packet(input logic [31:0] sip, input logic [31:0] dip, input logic [7:0] proto,
                             input logic [15:0] sp, input logic [15:0] dp, input int len);
    logic [7:0] bytes [$];
    logic       users [$];
    int         st;
    for (int k = 0; k < len; k++) begin
      case (k)
        0: bytes.push_back(sp[15:8]);
        1: bytes.push_back(sp[7:0]);
        2: bytes.push_back(dp[15:8]);
        3: bytes.push_back(dp[7:0]);
        default: bytes.push_back(8'($urandom));
      endcase
      users.push_back((k >= 4 || k == len - 1) ? ($urandom_range(0, 9) == 0) : 1'b0);
    end
    st = (proto == 8'd6 && len >= 4) ? model_match(sp, dp, sip) : -1;
    $display("pkt  sip=%08h proto=%0d %0d->%0d len=%0d expect_stream=%0d", sip, proto, sp, dp, len, st);
    if (st >= 0) begin
      hexp_q.push_back('{stream: st, sip: sip, dip: dip});
      for (int k = 0; k < len; k++)
        exp_q.push_back('{stream: st, data: bytes[k], last: (k == len - 1), user: users[k]});
      exp_rx[st]++;
    end else begin
      exp_drops++;
    end
    s_ip_hdr_valid = 1'b1;
    s_ip_source_ip = sip;
    s_ip_dest_ip   = dip;
    s_ip_protocol  = proto;
    wait_hs(1'b1, "hdr");
    s_ip_hdr_valid = 1'b0;
    for (int k = 0; k < len; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        s_ip_payload_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_ip_payload_tvalid = 1'b1;
      s_ip_payload_tdata  = bytes[k];
      s_ip_payload_tlast  = (k == len - 1);
      s_ip_payload_tuser  = users[k];
      wait_hs(1'b0, "payload");
    end
    s_ip_payload_tvalid = 1'b0;
    s_ip_payload_tlast  = 1'b0;
    s_ip_payload_tuser  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || hexp_q.size() != 0) && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 5000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic clear_cfg();
    cfg_en = '0;
    for (int i = 0; i < N; i++) begin
      t_lport[i] = 16'd0;
      t_rport[i] = 16'd0;
      t_rip[i]   = 32'd0;
    end
  endtask

  initial begin
    logic [31:0] ips [3];
    logic [15:0] lps [4];
    ips[0] = 32'h0A000002;
    ips[1] = 32'h0A000003;
    ips[2] = 32'hC0A80001;
    lps[0] = 16'd80;
    lps[1] = 16'd81;
    lps[2] = 16'd82;
    lps[3] = 16'd23;
    for (int i = 0; i < N; i++) exp_rx[i] = 0;
    clear_cfg();
    rst                 = 1'b1;
    s_ip_hdr_valid      = 1'b0;
    s_ip_source_ip      = '0;
    s_ip_dest_ip        = '0;
    s_ip_protocol       = '0;
    s_ip_payload_tdata  = '0;
    s_ip_payload_tvalid = 1'b0;
    s_ip_payload_tlast  = 1'b0;
    s_ip_payload_tuser  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hdr_ready", 64'(s_ip_hdr_ready), 64'd0);
    check("rst_payload_tready", 64'(s_ip_payload_tready), 64'd0);
    check("rst_hdr_valid", 64'(m_ip_hdr_valid), 64'd0);
    check("rst_tvalid", 64'(m_ip_payload_tvalid), 64'd0);
    check("rst_source_ip", 64'(m_ip_source_ip), 64'd0);
    check("rst_tdata", 64'(m_ip_payload_tdata), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_hdr_ready", 64'(s_ip_hdr_ready), 64'd1);
    @(posedge clk);
    #1;

    // Stream 2 on port 80 with wildcard remote.
    cfg_en[2] = 1'b1;
    t_lport[2] = 16'd80;
    send_packet(32'h0A000003, 32'h0A000001, 8'd6, 16'd1234, 16'd80, 20);
    drain();

    // Two streams on port 23: the lower index wins.
    clear_cfg();
    cfg_en[1] = 1'b1;
    t_lport[1] = 16'd23;
    cfg_en[5] = 1'b1;
    t_lport[5] = 16'd23;
    send_packet(32'h0A000004, 32'h0A000001, 8'd6, 16'd4000, 16'd23, 12);
    drain();

    // UDP packet, runt, then a normal packet.
    send_packet(32'h0A000004, 32'h0A000001, 8'd17, 16'd4000, 16'd23, 10);
    send_packet(32'h0A000004, 32'h0A000001, 8'd6, 16'd4000, 16'd23, 3);
    send_packet(32'h0A000004, 32'h0A000001, 8'd6, 16'd4000, 16'd23, 4);
    send_packet(32'h0A000004, 32'h0A000001, 8'd6, 16'd4000, 16'd23, 9);
    drain();

    // Long packet under 30% sink backpressure.
    bp_pct = 30;
    send_packet(32'h0A000005, 32'h0A000001, 8'd6, 16'd999, 16'd23, 100);
    drain();

    // Remote IP/port filtering on stream 0.
    clear_cfg();
    cfg_en[0]  = 1'b1;
    t_lport[0] = 16'd7000;
    t_rport[0] = 16'd5000;
    t_rip[0]   = 32'h0A000002;
    send_packet(32'h0A000003, 32'h0A000001, 8'd6, 16'd5000, 16'd7000, 8);
    send_packet(32'h0A000002, 32'h0A000001, 8'd6, 16'd5000, 16'd7000, 8);
    drain();

    // Random configurations and traffic.
    for (int r = 0; r < 6; r++) begin
      clear_cfg();
      for (int i = 0; i < N; i++) begin
        cfg_en[i]  = ($urandom_range(0, 3) != 0);
        t_lport[i] = lps[$urandom_range(0, 3)];
        t_rport[i] = ($urandom_range(0, 1) == 1) ? 16'd0 : 16'(1000 + $urandom_range(0, 1));
        t_rip[i]   = ($urandom_range(0, 1) == 1) ? 32'd0 : ips[$urandom_range(0, 1)];
      end
      bp_pct = $urandom_range(0, 50);
      for (int p = 0; p < 8; p++) begin
        send_packet(ips[$urandom_range(0, 2)], 32'h0A000001,
                    ($urandom_range(0, 9) == 0) ? 8'd17 : 8'd6,
                    16'(1000 + $urandom_range(0, 2)),
                    ($urandom_range(0, 4) == 4) ? 16'd99 : lps[$urandom_range(0, 3)],
                    $urandom_range(1, 30));
      end
      drain();
    end

    check("final_beat_queue", 64'(exp_q.size()), 64'd0);
    check("final_hdr_queue", 64'(hexp_q.size()), 64'd0);
`ifdef TCP_RX_DEMUX_STATS_EN
    check("drop_count", 64'(drop_count), 64'(exp_drops));
    for (int i = 0; i < N; i++)
      check("rx_count", 64'(rx_count[i*16 +: 16]), 64'(exp_rx[i]));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
